vram_bus_initiator: RTL and testbench
=====================================

Name: vram_bus_initiator

Overview:
- Initiator side of the 14-bit VRAM byte bus: bus_address/valid/ready/write/wdata/rdata/rdata_en.
- Sits between the VDP CPU data-port logic and the VRAM responder.
- Implements TMS9918-style port access:
  - address latch with auto-increment;
  - read-ahead (prefetch) buffer;
  - write-through into the read buffer;
  - watchdog timeout on read returns.

Parameters:
- ADDR_W, 14, VRAM address width; bus_address, cmd_addr and the address counter are all this width.
- RD_TIMEOUT, 15, maximum cycles spent in WAIT_RD before a read is abandoned (1..255).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  2  00 SET_ADDR_W, 01 SET_ADDR_R, 10 WRITE_DATA, 11 READ_DATA
- cmd_addr  in  ADDR_W  address for SET_ADDR_*
- cmd_wdata  in  8  data for WRITE_DATA
- rd_data  out  8  read-ahead buffer
- rd_data_valid  out  1  read-ahead buffer holds current data
- timeout_err  out  1  sticky; a read timed out
- bus_address  out  ADDR_W  VRAM address
- bus_valid  out  1  request
- bus_ready  in  1  responder accepts request this cycle
- bus_write  out  1  1=write, 0=read
- bus_wdata  out  8  write data
- bus_rdata  in  8  read data
- bus_rdata_en  in  1  bus_rdata valid this cycle

Behaviour:
- Reset: clk and reset_n are as already decided (reset_n synchronous, active-low; clock clk).
  - State IDLE, address counter 0.
  - Outputs: bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0, rd_data=0x00, rd_data_valid=0, timeout_err=0, cmd_ready=1.
- cmd_ready is 1 only in state IDLE; it is a registered-state decode, not combinational on cmd_valid.
- FSM states: IDLE, REQ, WAIT_RD.
- IDLE, on accept:
  - SET_ADDR_W: addr<=cmd_addr; stay IDLE; no bus traffic; rd_data unchanged.
  - SET_ADDR_R: addr<=cmd_addr; rd_data_valid<=0; go REQ with read.
  - READ_DATA: the caller consumes rd_data in the accept cycle; rd_data_valid<=0; go REQ with read at current addr.
  - WRITE_DATA: go REQ with write at current addr, bus_wdata<=cmd_wdata; rd_data<=cmd_wdata; rd_data_valid<=1.
- REQ:
  - bus_valid=1; bus_address, bus_write and bus_wdata are registered and held stable until bus_ready=1.
  - On the cycle with bus_ready=1: bus_valid<=0 and addr<=addr+1, modulo 2^ADDR_W (0x3FFF wraps to 0x0000).
  - Next state: write goes to IDLE; read goes to WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - bus_valid=0; the counter increments each cycle.
  - bus_rdata_en=1: rd_data<=bus_rdata, rd_data_valid<=1, go IDLE.
  - Else if counter reaches RD_TIMEOUT-1: rd_data<=0xFF, rd_data_valid<=1, timeout_err<=1, go IDLE.
  - rdata_en coinciding with expiry: data wins; timeout_err is not set.
- bus_rdata_en is ignored in IDLE and REQ; stray or late beats change nothing.
- Exactly one outstanding bus request at a time; no new request is issued before the read return or timeout.
- Latency with a responder of ready=1 and 3-cycle read pipeline, accept at cycle 0:
  - bus_valid high in cycle 1;
  - bus_rdata_en in cycle 4;
  - rd_data/rd_data_valid updated and cmd_ready=1 in cycle 5.
- Write with ready=1: bus_valid in cycle 1, cmd_ready=1 in cycle 2.
- Reset asserted mid-operation (REQ or WAIT_RD): next edge returns everything to reset values; bus_valid drops; pending response is discarded.
- timeout_err is cleared only by reset.

Test Plan:
- Write path: SET_ADDR_W 0x1234, WRITE_DATA 0x5A, WRITE_DATA 0xA5 -> two single-cycle bus writes:
  - addr 0x1234 data 5A, then addr 0x1235 data A5;
  - rd_data=0xA5 valid; counter at 0x1236.
- Read path: after the above, SET_ADDR_R 0x1234 accepted at cycle 0 -> bus read at 0x1234 in cycle 1; rd_data=0x5A, rd_data_valid=1, cmd_ready=1 in cycle 5.
  - Then READ_DATA -> rd_data_valid=0 until 0xA5 appears from addr 0x1235.
- Wrap: SET_ADDR_W 0x3FFF, WRITE_DATA 0x11, WRITE_DATA 0x22 -> bus addresses 0x3FFF then 0x0000.
- Backpressure: bus_ready low for 3 cycles during a write -> bus_valid high 4 cycles with address/data stable, cmd_ready low throughout, exactly one write committed.
- Timeout: responder never asserts bus_rdata_en on SET_ADDR_R -> after RD_TIMEOUT=15 cycles in WAIT_RD: rd_data=0xFF, rd_data_valid=1, timeout_err=1, stays 1.
  - Variant: rdata_en on the expiry cycle -> real data, timeout_err=0.
- Reset mid-read: reset_n low one cycle during WAIT_RD, then late bus_rdata_en=1 with data 0x77 -> ignored; rd_data=0x00, rd_data_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/vram_bus_initiator.sv
// VRAM byte-bus initiator for the VDP CPU data port: address latch with
// auto-increment, read-ahead buffer, write-through, and a read-return watchdog.
module vram_bus_initiator #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic [7:0]        rd_data,
    output logic              rd_data_valid,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_write,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_rdata_en
);

    localparam logic [1:0] OP_SET_ADDR_W = 2'b00;
    localparam logic [1:0] OP_SET_ADDR_R = 2'b01;
    localparam logic [1:0] OP_WRITE_DATA = 2'b10;
    localparam logic [7:0] WAIT_LAST     = 8'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wait_cnt;

    // cmd_ready is registered alongside state so it always equals (state == IDLE).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            wait_cnt      <= 8'd0;
            cmd_ready     <= 1'b1;
            rd_data       <= 8'h00;
            rd_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
            bus_address   <= '0;
            bus_valid     <= 1'b0;
            bus_write     <= 1'b0;
            bus_wdata     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_SET_ADDR_W: begin
                                addr <= cmd_addr;
                            end
                            OP_SET_ADDR_R: begin
                                addr          <= cmd_addr;
                                bus_address   <= cmd_addr;
                                bus_write     <= 1'b0;
                                bus_valid     <= 1'b1;
                                rd_data_valid <= 1'b0;
                                cmd_ready     <= 1'b0;
                                state         <= REQ;
                            end
                            OP_WRITE_DATA: begin
                                bus_address   <= addr;
                                bus_write     <= 1'b1;
                                bus_wdata     <= cmd_wdata;
                                bus_valid     <= 1'b1;
                                rd_data       <= cmd_wdata;
                                rd_data_valid <= 1'b1;
                                cmd_ready     <= 1'b0;
                                state         <= REQ;
                            end
                            default: begin
                                // READ_DATA: caller took rd_data this cycle; refill from addr
                                bus_address   <= addr;
                                bus_write     <= 1'b0;
                                bus_valid     <= 1'b1;
                                rd_data_valid <= 1'b0;
                                cmd_ready     <= 1'b0;
                                state         <= REQ;
                            end
                        endcase
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        addr      <= addr + ADDR_W'(1);
                        wait_cnt  <= 8'd0;
                        if (bus_write) begin
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A return on the expiry cycle wins over the timeout.
                    if (bus_rdata_en) begin
                        rd_data       <= bus_rdata;
                        rd_data_valid <= 1'b1;
                        cmd_ready     <= 1'b1;
                        state         <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rd_data       <= 8'hFF;
                        rd_data_valid <= 1'b1;
                        timeout_err   <= 1'b1;
                        cmd_ready     <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_bus_initiator.sv
// Scoreboarded bench for vram_bus_initiator with a behavioural VRAM responder.
module tb_vram_bus_initiator;

    localparam int unsigned AW = 14;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_wdata;
    logic [7:0]    rd_data;
    logic          rd_data_valid;
    logic          timeout_err;
    logic [AW-1:0] bus_address;
    logic          bus_valid;
    logic          bus_ready;
    logic          bus_write;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          bus_rdata_en;

    vram_bus_initiator #(.ADDR_W(AW), .RD_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .timeout_err(timeout_err),
        .bus_address(bus_address), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_write(bus_write), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } bus_op_t;

    bus_op_t       exp_q[$];
    logic [7:0]    vram[0:(1<<AW)-1];
    logic [AW-1:0] model_addr;
    int            checks = 0;
    int            failures = 0;
    int            stall_left = 0;
    int            rd_lat = 3;
    bit            drop_rd = 1'b0;
    int            ret_cnt = 0;
    bit            ret_pending = 1'b0;
    logic [7:0]    ret_data = 8'h00;
    int            commits = 0;

    // Responder: decides ready/rdata_en at the falling edge, checks each handshake.
    initial begin
        bus_op_t op;
        bus_ready = 1'b1;
        bus_rdata_en = 1'b0;
        bus_rdata = 8'h00;
        for (int i = 0; i < (1 << AW); i++) vram[i] = 8'h00;
        forever begin
            @(negedge clk);
            bus_rdata_en = 1'b0;
            if (ret_pending) begin
                ret_cnt--;
                if (ret_cnt <= 0) begin
                    bus_rdata_en = 1'b1;
                    bus_rdata = ret_data;
                    ret_pending = 1'b0;
                end
            end
            if (bus_valid && stall_left > 0) begin
                bus_ready = 1'b0;
                stall_left--;
            end else begin
                bus_ready = 1'b1;
            end
            if (bus_valid && bus_ready) begin
                commits++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected got wr=%0b addr=%h data=%h required none",
                             bus_write, bus_address, bus_wdata);
                end else begin
                    op = exp_q.pop_front();
                    if (bus_write !== op.wr || bus_address !== op.a ||
                        (op.wr && bus_wdata !== op.d)) begin
                        failures++;
                        $display("FAIL bus_op got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                                 bus_write, bus_address, bus_wdata, op.wr, op.a, op.d);
                    end
                end
                if (bus_write) begin
                    vram[bus_address] = bus_wdata;
                end else if (!drop_rd) begin
                    ret_pending = 1'b1;
                    ret_cnt = rd_lat;
                    ret_data = vram[bus_address];
                end
            end
        end
    end

    // Drive one command; returns just after the accepting edge (i.e. in cycle 1).
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d);
        int n;
        bus_op_t e;
        @(negedge clk);
        cmd_op = op;
        cmd_addr = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept got cmd_ready=%b required 1 within 200 cycles", cmd_ready);
        end
        case (op)
            2'b00: model_addr = a;
            2'b01: begin
                model_addr = a;
                e.wr = 1'b0; e.a = model_addr; e.d = 8'h00;
                exp_q.push_back(e);
                model_addr = model_addr + AW'(1);
            end
            2'b10: begin
                e.wr = 1'b1; e.a = model_addr; e.d = d;
                exp_q.push_back(e);
                model_addr = model_addr + AW'(1);
            end
            default: begin
                e.wr = 1'b0; e.a = model_addr; e.d = 8'h00;
                exp_q.push_back(e);
                model_addr = model_addr + AW'(1);
            end
        endcase
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns the cycle index (accept = cycle 0) at which cmd_ready is seen high.
    task automatic wait_idle(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cmd_ready !== 1'b1 && k < 300);
        if (k >= 300) begin
            checks++;
            failures++;
            $display("FAIL idle_wait got cmd_ready=%b required 1 within 300 cycles", cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_addr = '0;
        cmd_wdata = 8'h00;
        model_addr = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if ({cmd_ready, bus_valid, bus_write, timeout_err, rd_data_valid} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got %b required 10000",
                     {cmd_ready, bus_valid, bus_write, timeout_err, rd_data_valid});
        end
        checks++;
        if ({bus_address, bus_wdata, rd_data} !== {14'h0000, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rd=%h required 0", bus_address, bus_wdata, rd_data);
        end
    endtask

    task automatic test_write_path();
        int k;
        send(2'b00, 14'h1234, 8'h00);
        send(2'b10, 14'h0000, 8'h5A);
        wait_idle(k);
        send(2'b10, 14'h0000, 8'hA5);
        wait_idle(k);
        checks++;
        if (k !== 2) begin
            failures++;
            $display("FAIL write_latency got idle_cycle=%0d required 2", k);
        end
        checks++;
        if (rd_data !== 8'hA5 || rd_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_through got rd=%h v=%b required A5 1", rd_data, rd_data_valid);
        end
        // Next access must land at 0x1236.
        send(2'b11, 14'h0000, 8'h00);
        wait_idle(k);
    endtask

    task automatic test_read_path();
        int k;
        send(2'b01, 14'h1234, 8'h00);
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_address !== 14'h1234) begin
            failures++;
            $display("FAIL read_req_cycle1 got v=%b w=%b a=%h required 1 0 1234", bus_valid, bus_write, bus_address);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_cycle4 got rdy=%b v=%b required 0 0", cmd_ready, rd_data_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rd_data_valid !== 1'b1 || rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL read_cycle5 got rdy=%b v=%b rd=%h required 1 1 5A", cmd_ready, rd_data_valid, rd_data);
        end
        send(2'b11, 14'h0000, 8'h00);
        @(negedge clk);
        checks++;
        if (rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL readahead_invalidate got v=%b required 0", rd_data_valid);
        end
        wait_idle(k);
        checks++;
        if (rd_data !== 8'hA5 || rd_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL readahead_next got rd=%h v=%b required A5 1", rd_data, rd_data_valid);
        end
    endtask

    task automatic test_wrap();
        int k;
        send(2'b00, 14'h3FFF, 8'h00);
        send(2'b10, 14'h0000, 8'h11);
        wait_idle(k);
        send(2'b10, 14'h0000, 8'h22);
        wait_idle(k);
        send(2'b01, 14'h3FFF, 8'h00);
        wait_idle(k);
        checks++;
        if (rd_data !== 8'h11) begin
            failures++;
            $display("FAIL wrap_read0 got %h required 11", rd_data);
        end
        send(2'b11, 14'h0000, 8'h00);
        wait_idle(k);
        checks++;
        if (rd_data !== 8'h22) begin
            failures++;
            $display("FAIL wrap_read1 got %h required 22", rd_data);
        end
    endtask

    task automatic test_backpressure();
        int c0;
        send(2'b00, 14'h0200, 8'h00);
        stall_left = 3;
        c0 = commits;
        send(2'b10, 14'h0000, 8'h3C);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus_valid !== 1'b1 || bus_address !== 14'h0200 || bus_wdata !== 8'h3C || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d got v=%b a=%h d=%h rdy=%b required 1 0200 3C 0",
                         i, bus_valid, bus_address, bus_wdata, cmd_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b0 || cmd_ready !== 1'b1 || (commits - c0) !== 1) begin
            failures++;
            $display("FAIL stall_release got v=%b rdy=%b commits=%0d required 0 1 1",
                     bus_valid, cmd_ready, commits - c0);
        end
    endtask

    task automatic test_expiry_race();
        int k;
        rd_lat = 15;
        send(2'b01, 14'h1234, 8'h00);
        wait_idle(k);
        rd_lat = 3;
        checks++;
        if (k !== 17 || rd_data !== 8'h5A || rd_data_valid !== 1'b1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL expiry_race got cyc=%0d rd=%h v=%b to=%b required 17 5A 1 0",
                     k, rd_data, rd_data_valid, timeout_err);
        end
    endtask

    task automatic test_timeout();
        int k;
        drop_rd = 1'b1;
        send(2'b01, 14'h0300, 8'h00);
        wait_idle(k);
        drop_rd = 1'b0;
        checks++;
        if (k !== 17 || rd_data !== 8'hFF || rd_data_valid !== 1'b1 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout got cyc=%0d rd=%h v=%b to=%b required 17 FF 1 1",
                     k, rd_data, rd_data_valid, timeout_err);
        end
        send(2'b10, 14'h0000, 8'h44);
        wait_idle(k);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got %b required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_read();
        vram[14'h0400] = 8'h77;
        rd_lat = 6;
        send(2'b01, 14'h0400, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_addr = '0;
        for (int i = 4; i <= 9; i++) begin
            checks++;
            if ({cmd_ready, bus_valid, rd_data_valid, timeout_err} !== 4'b1000 || rd_data !== 8'h00) begin
                failures++;
                $display("FAIL reset_mid_read_c%0d got rdy=%b v=%b dv=%b to=%b rd=%h required 1 0 0 0 00",
                         i, cmd_ready, bus_valid, rd_data_valid, timeout_err, rd_data);
            end
            @(negedge clk);
        end
        rd_lat = 3;
    endtask

    initial begin
        test_reset();
        test_write_path();
        test_read_path();
        test_wrap();
        test_backpressure();
        test_expiry_race();
        test_timeout();
        test_reset_mid_read();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish required finish before 500000");
        $fatal(1, "simulation time limit");
    end

endmodule
